out_mem_checker: RTL and testbench

- Hardware self-check engine for NPU conv/tile layers.
- Streams a window of the output BRAM B-port alongside a golden-reference BRAM, one word per cycle, and compares them lane by lane, in exact mode or with a per-lane tolerance.
- Reports pass/fail, a saturating error count and the first mismatch.
- Sits beside `top` and replaces the bench-side compare loop, so on-chip (FPGA) regression runs need no simulator.

---
 rtl/out_mem_checker.sv | 206 ++++++++++++++++++++
 tb/tb_out_mem_checker.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_mem_checker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : out_mem_checker
// Description : Streams an output-BRAM window against a golden BRAM and
//               compares lane by lane (exact or per-lane tolerance).
// Revision    : 1.0 - initial release
// ============================================================================
module out_mem_checker #(
    parameter int DATA_W   = 32,
    parameter int LANE_W   = 8,
    parameter int ADDR_W   = 16,
    parameter int READ_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     num_words,
    input  logic                tol_mode,
    input  logic [LANE_W-1:0]   tol,
    input  logic                stop_on_err,
    output logic                mem_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_dout,
    output logic                gold_en,
    output logic [ADDR_W-1:0]   gold_addr,
    input  logic [DATA_W-1:0]   gold_dout,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [CNT_W-1:0]    err_cnt,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [DATA_W-1:0]   first_err_dut,
    output logic [DATA_W-1:0]   first_err_gold
);

    localparam int N_LANES = DATA_W / LANE_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t              state_q;
    logic [ADDR_W:0]     remain_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                mem_en_q;
    logic                tol_mode_q;
    logic [LANE_W-1:0]   tol_q;
    logic                stop_on_err_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;
    logic [CNT_W-1:0]    err_cnt_q;
    logic [CNT_W-1:0]    err_cnt_d;
    logic [ADDR_W-1:0]   first_addr_q;
    logic [DATA_W-1:0]   first_dut_q;
    logic [DATA_W-1:0]   first_gold_q;

    logic [READ_LAT-1:0] pipe_vld_q;
    logic [ADDR_W-1:0]   pipe_addr_q [READ_LAT];
    logic                head_busy;

    logic [N_LANES-1:0]  lane_bad;
    logic                mismatch;
    logic                cmp_err;

    // Lanes are widened by one bit so the signed difference can never wrap.
    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        logic [LANE_W:0] dut_ext;
        logic [LANE_W:0] gold_ext;
        logic [LANE_W:0] diff;
        logic [LANE_W:0] mag;
        assign dut_ext  = {mem_dout[g*LANE_W+LANE_W-1],  mem_dout[g*LANE_W +: LANE_W]};
        assign gold_ext = {gold_dout[g*LANE_W+LANE_W-1], gold_dout[g*LANE_W +: LANE_W]};
        assign diff     = dut_ext - gold_ext;
        assign mag      = diff[LANE_W] ? ((~diff) + (LANE_W+1)'(1)) : diff;
        assign lane_bad[g] = (mag > {1'b0, tol_q});
    end

    assign mismatch = tol_mode_q ? (|lane_bad) : (mem_dout != gold_dout);
    assign cmp_err  = pipe_vld_q[READ_LAT-1] & mismatch;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (cmp_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    // Only the tail may still hold a read when the pipeline is about to empty.
    always_comb begin
        head_busy = 1'b0;
        for (int j = 0; j < READ_LAT - 1; j++) begin
            head_busy = head_busy | pipe_vld_q[j];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pipe_vld_q <= '0;
            for (int j = 0; j < READ_LAT; j++) begin
                pipe_addr_q[j] <= '0;
            end
        end else begin
            pipe_vld_q[0]  <= mem_en_q;
            pipe_addr_q[0] <= addr_q;
            for (int j = 1; j < READ_LAT; j++) begin
                pipe_vld_q[j]  <= pipe_vld_q[j-1];
                pipe_addr_q[j] <= pipe_addr_q[j-1];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            remain_q      <= '0;
            addr_q        <= '0;
            mem_en_q      <= 1'b0;
            tol_mode_q    <= 1'b0;
            tol_q         <= '0;
            stop_on_err_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            err_cnt_q     <= '0;
            first_addr_q  <= '0;
            first_dut_q   <= '0;
            first_gold_q  <= '0;
        end else begin
            done_q    <= 1'b0;
            err_cnt_q <= err_cnt_d;
            if (cmp_err && (err_cnt_q == '0)) begin
                first_addr_q <= pipe_addr_q[READ_LAT-1];
                first_dut_q  <= mem_dout;
                first_gold_q <= gold_dout;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q        <= base_addr;
                        remain_q      <= num_words;
                        tol_mode_q    <= tol_mode;
                        tol_q         <= tol;
                        stop_on_err_q <= stop_on_err;
                        busy_q        <= 1'b1;
                        pass_q        <= 1'b0;
                        err_cnt_q     <= '0;
                        first_addr_q  <= '0;
                        first_dut_q   <= '0;
                        first_gold_q  <= '0;
                        // An empty window passes through DRAIN so done keeps the N+L+1 cadence.
                        if (num_words == '0) begin
                            state_q <= S_DRAIN;
                        end else begin
                            state_q  <= S_ISSUE;
                            mem_en_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    addr_q   <= addr_q + ADDR_W'(1);
                    remain_q <= remain_q - (ADDR_W+1)'(1);
                    if ((remain_q == (ADDR_W+1)'(1)) || (stop_on_err_q && cmp_err)) begin
                        state_q  <= S_DRAIN;
                        mem_en_q <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (!head_busy) begin
                        state_q <= S_FIN;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        pass_q  <= (err_cnt_d == '0);
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_en         = mem_en_q;
    assign gold_en        = mem_en_q;
    assign mem_addr       = addr_q;
    assign gold_addr      = addr_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_addr_q;
    assign first_err_dut  = first_dut_q;
    assign first_err_gold = first_gold_q;

endmodule
`default_nettype wire

// File: tb/tb_out_mem_checker.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for out_mem_checker: three instances at READ_LAT 1/2/3
// sharing behavioural output and golden BRAM models.
module tb_out_mem_checker;

    localparam int DW = 32;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          resetn;
    logic [2:0]    start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_words;
    logic          tol_mode;
    logic [7:0]    tol;
    logic          stop_on_err;

    logic [2:0]    mem_en;
    logic [2:0]    gold_en;
    logic [AW-1:0] mem_addr  [3];
    logic [AW-1:0] gold_addr [3];
    logic [DW-1:0] mem_dout  [3];
    logic [DW-1:0] gold_dout [3];
    logic [2:0]    busy;
    logic [2:0]    done;
    logic [2:0]    pass;
    logic [15:0]   err_cnt   [3];
    logic [AW-1:0] faddr     [3];
    logic [DW-1:0] fdut      [3];
    logic [DW-1:0] fgold     [3];

    logic [DW-1:0] dut_mem  [0:65535];
    logic [DW-1:0] gold_mem [0:65535];

    int checks   = 0;
    int failures = 0;

    int            r_done_cyc, r_en_cnt, r_en_first, r_en_last;
    logic [AW-1:0] addr_log  [8];
    logic [AW-1:0] gaddr_log [8];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int CW = (k == 2) ? 4 : 16;
        logic [DW-1:0] md_q [0:k];
        logic [DW-1:0] gd_q [0:k];
        logic [CW-1:0] ec;

        always @(posedge clk) begin
            if (mem_en[k])  md_q[0] <= dut_mem[mem_addr[k]];
            if (gold_en[k]) gd_q[0] <= gold_mem[gold_addr[k]];
            for (int j = 1; j <= k; j++) begin
                md_q[j] <= md_q[j-1];
                gd_q[j] <= gd_q[j-1];
            end
        end
        assign mem_dout[k]  = md_q[k];
        assign gold_dout[k] = gd_q[k];
        assign err_cnt[k]   = 16'(ec);

        out_mem_checker #(
            .DATA_W(DW), .LANE_W(8), .ADDR_W(AW), .READ_LAT(k + 1), .CNT_W(CW)
        ) u_dut (
            .clk(clk), .resetn(resetn), .start(start[k]),
            .base_addr(base_addr), .num_words(num_words),
            .tol_mode(tol_mode), .tol(tol), .stop_on_err(stop_on_err),
            .mem_en(mem_en[k]), .mem_addr(mem_addr[k]), .mem_dout(mem_dout[k]),
            .gold_en(gold_en[k]), .gold_addr(gold_addr[k]), .gold_dout(gold_dout[k]),
            .busy(busy[k]), .done(done[k]), .pass(pass[k]), .err_cnt(ec),
            .first_err_addr(faddr[k]), .first_err_dut(fdut[k]), .first_err_gold(fgold[k])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycle 0 ends at the edge that samples start; counts cycles 1.. at negedges.
    task automatic run(input int k, input logic [AW-1:0] b, input logic [AW:0] n,
                       input logic tm, input logic [7:0] tl, input logic soe);
        @(negedge clk);
        base_addr = b; num_words = n; tol_mode = tm; tol = tl; stop_on_err = soe;
        start[k] = 1'b1;
        @(posedge clk);
        #1 start[k] = 1'b0;
        r_done_cyc = -1; r_en_cnt = 0; r_en_first = -1; r_en_last = -1;
        for (int c = 1; c <= int'(n) + 20; c++) begin
            @(negedge clk);
            if (mem_en[k]) begin
                if (r_en_cnt < 8) begin
                    addr_log[r_en_cnt]  = mem_addr[k];
                    gaddr_log[r_en_cnt] = gold_addr[k];
                end
                if (r_en_first < 0) r_en_first = c;
                r_en_last = c;
                r_en_cnt++;
            end
            if (done[k]) begin
                r_done_cyc = c;
                break;
            end
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 65536; i++) begin
            dut_mem[i]  = i * 32'h9E3779B1;
            gold_mem[i] = i * 32'h9E3779B1;
        end
    endtask

    initial begin
        resetn = 1'b0; start = '0; base_addr = '0; num_words = '0;
        tol_mode = 1'b0; tol = '0; stop_on_err = 1'b0;
        fill_mem();
        repeat (3) @(negedge clk);
        chk("rst_busy",    64'(busy),        64'h0);
        chk("rst_done",    64'(done),        64'h0);
        chk("rst_pass",    64'(pass),        64'h0);
        chk("rst_mem_en",  64'(mem_en),      64'h0);
        chk("rst_err_cnt", 64'(err_cnt[0]),  64'h0);
        chk("rst_addr",    64'(mem_addr[0]), 64'h0);
        chk("rst_faddr",   64'(faddr[0]),    64'h0);
        resetn = 1'b1;

        // Full pass, N=1000, L=1
        run(0, 16'd0, 17'd1000, 1'b0, 8'd0, 1'b0);
        chk("full_done_cyc", 64'(r_done_cyc), 64'd1002);
        chk("full_pass",     64'(pass[0]),    64'd1);
        chk("full_err",      64'(err_cnt[0]), 64'd0);
        chk("full_en_first", 64'(r_en_first), 64'd1);
        chk("full_en_last",  64'(r_en_last),  64'd1000);
        chk("full_en_cnt",   64'(r_en_cnt),   64'd1000);
        @(negedge clk);
        chk("full_pass_hold", 64'(pass[0]), 64'd1);
        chk("full_busy_low",  64'(busy[0]), 64'd0);

        // Single exact-mode mismatch at 37
        dut_mem[37] = 32'h12345678; gold_mem[37] = 32'h12345679;
        run(0, 16'd0, 17'd64, 1'b0, 8'd0, 1'b0);
        chk("one_done_cyc", 64'(r_done_cyc), 64'd66);
        chk("one_pass",     64'(pass[0]),    64'd0);
        chk("one_err",      64'(err_cnt[0]), 64'd1);
        chk("one_faddr",    64'(faddr[0]),   64'd37);
        chk("one_fdut",     64'(fdut[0]),    64'h12345678);
        chk("one_fgold",    64'(fgold[0]),   64'h12345679);
        fill_mem();

        // Tolerance window at 2000..2007: words 0,1,4,5,7 differ by +/-2 per lane
        for (int i = 0; i < 8; i++) begin
            gold_mem[2000+i] = 32'h10203040;
            dut_mem[2000+i]  = 32'h10203040;
        end
        dut_mem[2000] = 32'h121E323E; dut_mem[2004] = 32'h121E323E;
        dut_mem[2005] = 32'h121E323E; dut_mem[2007] = 32'h121E323E;
        gold_mem[2001] = 32'hFE01FF80; dut_mem[2001] = 32'h00FF0182;
        run(0, 16'd2000, 17'd8, 1'b1, 8'd2, 1'b0);
        chk("tol2_pass", 64'(pass[0]),    64'd1);
        chk("tol2_err",  64'(err_cnt[0]), 64'd0);
        run(0, 16'd2000, 17'd8, 1'b1, 8'd1, 1'b0);
        chk("tol1_pass",  64'(pass[0]),    64'd0);
        chk("tol1_err",   64'(err_cnt[0]), 64'd5);
        chk("tol1_faddr", 64'(faddr[0]),   64'd2000);
        run(0, 16'd2000, 17'd8, 1'b0, 8'd2, 1'b0);
        chk("exact_err", 64'(err_cnt[0]), 64'd5);

        // 0x7F vs 0x80 is a 255 difference, not -1
        dut_mem[3000] = 32'h0000007F; gold_mem[3000] = 32'h00000080;
        run(0, 16'd3000, 17'd1, 1'b1, 8'd2, 1'b0);
        chk("wrap_lane_pass", 64'(pass[0]),    64'd0);
        chk("wrap_lane_err",  64'(err_cnt[0]), 64'd1);
        fill_mem();

        // stop_on_err, L=2: compare of addr 10 in cycle 13 halts issue
        dut_mem[10] = ~gold_mem[10]; dut_mem[11] = ~gold_mem[11];
        run(1, 16'd0, 17'd100, 1'b0, 8'd0, 1'b1);
        chk("soe_done_cyc", 64'(r_done_cyc), 64'd16);
        chk("soe_en_cnt",   64'(r_en_cnt),   64'd13);
        chk("soe_err",      64'(err_cnt[1]), 64'd2);
        chk("soe_faddr",    64'(faddr[1]),   64'd10);
        chk("soe_pass",     64'(pass[1]),    64'd0);
        fill_mem();

        // Empty window, then a start in the done cycle must be ignored
        run(0, 16'd5, 17'd0, 1'b0, 8'd0, 1'b0);
        chk("n0_done_cyc", 64'(r_done_cyc), 64'd2);
        chk("n0_pass",     64'(pass[0]),    64'd1);
        chk("n0_en_cnt",   64'(r_en_cnt),   64'd0);
        num_words = 17'd5; start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        @(negedge clk);
        chk("done_start_busy", 64'(busy[0]),   64'd0);
        chk("done_start_en",   64'(mem_en[0]), 64'd0);
        chk("done_start_pass", 64'(pass[0]),   64'd1);

        // Address wrap
        run(0, 16'hFFFE, 17'd4, 1'b0, 8'd0, 1'b0);
        chk("wrap_a0", 64'(addr_log[0]),  64'hFFFE);
        chk("wrap_a1", 64'(addr_log[1]),  64'hFFFF);
        chk("wrap_a2", 64'(addr_log[2]),  64'h0000);
        chk("wrap_a3", 64'(addr_log[3]),  64'h0001);
        chk("wrap_g3", 64'(gaddr_log[3]), 64'h0001);
        chk("wrap_pass", 64'(pass[0]),    64'd1);

        // READ_LAT=3 timing
        run(2, 16'd100, 17'd10, 1'b0, 8'd0, 1'b0);
        chk("l3_done_cyc", 64'(r_done_cyc), 64'd14);
        chk("l3_pass",     64'(pass[2]),    64'd1);

        // Saturation on the 4-bit counter instance: 20 mismatches
        for (int i = 0; i < 20; i++) dut_mem[4000+i] = ~gold_mem[4000+i];
        run(2, 16'd4000, 17'd20, 1'b0, 8'd0, 1'b0);
        chk("sat_err",      64'(err_cnt[2]), 64'hF);
        chk("sat_done_cyc", 64'(r_done_cyc), 64'd24);
        chk("sat_faddr",    64'(faddr[2]),   64'd4000);
        fill_mem();

        // Reset mid-check
        @(negedge clk);
        base_addr = '0; num_words = 17'd500; tol_mode = 1'b0; stop_on_err = 1'b0;
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        repeat (20) @(negedge clk);
        chk("mid_busy", 64'(busy[0]), 64'd1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_busy",  64'(busy[0]),     64'd0);
        chk("mid_rst_en",    64'(mem_en[0]),   64'd0);
        chk("mid_rst_addr",  64'(mem_addr[0]), 64'd0);
        chk("mid_rst_pass",  64'(pass[0]),     64'd0);
        chk("mid_rst_err",   64'(err_cnt[0]),  64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mid_rst_nodone", 64'(done[0]), 64'd0);
        end
        resetn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mid_post_nodone", 64'(done[0]), 64'd0);
        end
        dut_mem[37] = 32'h12345678; gold_mem[37] = 32'h12345679;
        run(0, 16'd0, 17'd64, 1'b0, 8'd0, 1'b0);
        chk("mid_new_done_cyc", 64'(r_done_cyc), 64'd66);
        chk("mid_new_err",      64'(err_cnt[0]), 64'd1);
        chk("mid_new_faddr",    64'(faddr[0]),   64'd37);
        chk("mid_new_pass",     64'(pass[0]),    64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
